// File: rtl/mac_accum.sv
// mac_accum: sums groups of COUNT unsigned products from the multiplier into
// an ACCWIDTH-bit result. Each finished frame is presented through a
// valid/ready handshake, together with a sticky wrap-around (overflow) flag.
module mac_accum #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned ACCWIDTH  = 16,
    parameter int unsigned COUNT     = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] prod,
    input  logic                 prod_valid,
    output logic                 prod_ready,
    input  logic                 clr,
    output logic [ACCWIDTH-1:0]  sum,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic                 ovf
);

    // With COUNT=1 the counter never leaves zero, but it still needs one bit.
    localparam int unsigned   CW   = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t              r_state;
    logic [ACCWIDTH-1:0] r_acc;
    logic [CW-1:0]       r_cnt;
    logic                r_run_ovf;
    logic [ACCWIDTH-1:0] r_sum;
    logic                r_sum_valid;
    logic                r_ovf;

    logic [ACCWIDTH:0]   w_add;
    logic                w_run_ovf;
    logic                w_accept;
    logic                w_last;

    // One extra bit on the adder captures the carry out of the accumulator.
    assign w_add      = {1'b0, r_acc} + {{(ACCWIDTH + 1 - DATAWIDTH){1'b0}}, prod};
    assign w_run_ovf  = r_run_ovf | w_add[ACCWIDTH];
    assign prod_ready = (r_state == ACCUM) && !clr;
    assign w_accept   = prod_valid && prod_ready;
    assign w_last     = (r_cnt == LAST);

    assign sum        = r_sum;
    assign sum_valid  = r_sum_valid;
    assign ovf        = r_ovf;

    // Frame control: accumulate in ACCUM, present the result in HOLD; clr aborts.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_run_ovf   <= 1'b0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (clr) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_run_ovf   <= 1'b0;
            r_sum_valid <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_sum       <= w_add[ACCWIDTH-1:0];
                            r_ovf       <= w_run_ovf;
                            r_sum_valid <= 1'b1;
                            r_state     <= HOLD;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_run_ovf   <= 1'b0;
                        end else begin
                            r_acc       <= w_add[ACCWIDTH-1:0];
                            r_cnt       <= r_cnt + CW'(1);
                            r_run_ovf   <= w_run_ovf;
                        end
                    end
                end
                HOLD: begin
                    if (r_sum_valid && sum_ready) begin
                        r_sum_valid <= 1'b0;
                        r_state     <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: a default instance (ACCWIDTH=16) and a narrow
// instance (ACCWIDTH=9) share all inputs; a reference model pushes expected
// frame results into per-instance queues that are popped when sum_valid rises.
module tb_mac_accum;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [7:0]  prod;
    logic        prod_valid;
    logic        clr;
    logic        sum_ready;

    logic        prod_ready_a, sum_valid_a, ovf_a;
    logic [15:0] sum_a;
    logic        prod_ready_b, sum_valid_b, ovf_b;
    logic [8:0]  sum_b;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] m_acc16;
    logic [8:0]  m_acc9;
    logic        m_ov16, m_ov9;
    int          m_cnt;
    logic [16:0] q16[$];   // {ovf, sum}
    logic [9:0]  q9[$];

    always #5 Clk = ~Clk;

    mac_accum #(.DATAWIDTH(8), .ACCWIDTH(16), .COUNT(4)) u_dut (
        .Clk(Clk), .Rst(Rst), .prod(prod), .prod_valid(prod_valid),
        .prod_ready(prod_ready_a), .clr(clr), .sum(sum_a),
        .sum_valid(sum_valid_a), .sum_ready(sum_ready), .ovf(ovf_a)
    );

    mac_accum #(.DATAWIDTH(8), .ACCWIDTH(9), .COUNT(4)) u_dut9 (
        .Clk(Clk), .Rst(Rst), .prod(prod), .prod_valid(prod_valid),
        .prod_ready(prod_ready_b), .clr(clr), .sum(sum_b),
        .sum_valid(sum_valid_b), .sum_ready(sum_ready), .ovf(ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc16 = '0; m_acc9 = '0; m_ov16 = 1'b0; m_ov9 = 1'b0; m_cnt = 0;
    endtask

    task automatic model_accept(input logic [7:0] p);
        logic [16:0] t16;
        logic [9:0]  t9;
        t16 = {1'b0, m_acc16} + {9'd0, p};
        t9  = {1'b0, m_acc9} + {2'd0, p};
        m_ov16  = m_ov16 | t16[16];
        m_ov9   = m_ov9 | t9[9];
        m_acc16 = t16[15:0];
        m_acc9  = t9[8:0];
        m_cnt++;
        if (m_cnt == 4) begin
            q16.push_back({m_ov16, m_acc16});
            q9.push_back({m_ov9, m_acc9});
            model_clear();
        end
    endtask

    // Called at a negedge: present p, wait (bounded) for ready, cross the accept edge.
    task automatic send(input logic [7:0] p);
        prod = p;
        prod_valid = 1'b1;
        #1;
        for (int i = 0; i < 20 && !prod_ready_a; i++) @(negedge Clk);
        chk("pready_wait", {31'd0, prod_ready_a}, 32'd1);
        @(posedge Clk);
        model_accept(p);
        @(negedge Clk);
    endtask

    // Called at a negedge: one raw cycle of stimulus, ready expected high.
    task automatic drive_raw(input logic v, input logic [7:0] p);
        prod = p;
        prod_valid = v;
        #1;
        chk("raw_pready", {31'd0, prod_ready_a}, 32'd1);
        @(posedge Clk);
        if (v) model_accept(p);
        @(negedge Clk);
    endtask

    // Wait (bounded) for a result and compare it against the scoreboard.
    task automatic get_result(input string tag);
        logic [16:0] e16;
        logic [9:0]  e9;
        for (int i = 0; i < 20 && !sum_valid_a; i++) @(negedge Clk);
        chk({tag, "_valid16"}, {31'd0, sum_valid_a}, 32'd1);
        chk({tag, "_valid9"},  {31'd0, sum_valid_b}, 32'd1);
        chk({tag, "_sbq"}, q16.size(), 32'd1);
        if (q16.size() > 0 && q9.size() > 0) begin
            e16 = q16.pop_front();
            e9  = q9.pop_front();
            chk({tag, "_sum16"}, {16'd0, sum_a}, {16'd0, e16[15:0]});
            chk({tag, "_ovf16"}, {31'd0, ovf_a}, {31'd0, e16[16]});
            chk({tag, "_sum9"},  {23'd0, sum_b}, {23'd0, e9[8:0]});
            chk({tag, "_ovf9"},  {31'd0, ovf_b}, {31'd0, e9[9]});
        end
    endtask

    initial begin
        Rst = 1'b0; prod = '0; prod_valid = 1'b0; clr = 1'b0; sum_ready = 1'b1;
        model_clear();

        // Reset state
        @(negedge Clk);
        chk("rst_sum", {16'd0, sum_a}, 32'd0);
        chk("rst_valid", {31'd0, sum_valid_a}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
        Rst = 1'b1;
        @(negedge Clk);
        chk("rst_pready", {31'd0, prod_ready_a}, 32'd1);

        // Basic frame
        send(8'd10); send(8'd20); send(8'd30); send(8'd40);
        prod_valid = 1'b0;
        chk("basic_lat_valid", {31'd0, sum_valid_a}, 32'd1);
        chk("basic_hold_pready", {31'd0, prod_ready_a}, 32'd0);
        get_result("basic");
        @(negedge Clk);
        chk("basic_after_valid", {31'd0, sum_valid_a}, 32'd0);
        chk("basic_after_pready", {31'd0, prod_ready_a}, 32'd1);

        // Backpressure
        sum_ready = 1'b0;
        send(8'd10); send(8'd20); send(8'd30); send(8'd40);
        prod = 8'd7; prod_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", {31'd0, sum_valid_a}, 32'd1);
            chk("bp_sum", {16'd0, sum_a}, 32'd100);
            chk("bp_pready", {31'd0, prod_ready_a}, 32'd0);
            @(negedge Clk);
        end
        prod_valid = 1'b0;
        get_result("bp");
        sum_ready = 1'b1;
        @(negedge Clk);
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        prod_valid = 1'b0;
        get_result("bp_next");
        @(negedge Clk);

        // Overflow (wraps in the 9-bit instance only)
        send(8'd255); send(8'd255); send(8'd255); send(8'd255);
        prod_valid = 1'b0;
        get_result("ovf");
        @(negedge Clk);
        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        prod_valid = 1'b0;
        get_result("ovf_next");
        @(negedge Clk);

        // Gapped input
        drive_raw(1'b1, 8'd3);  drive_raw(1'b0, 8'd99); drive_raw(1'b1, 8'd4);
        drive_raw(1'b0, 8'd99); drive_raw(1'b0, 8'd99); drive_raw(1'b1, 8'd5);
        drive_raw(1'b1, 8'd6);
        prod_valid = 1'b0;
        get_result("gap");
        @(negedge Clk);

        // Clear aborts the frame; the product presented with clr is dropped
        send(8'd5); send(8'd6);
        clr = 1'b1; prod = 8'd50; prod_valid = 1'b1;
        #1;
        chk("clr_pready", {31'd0, prod_ready_a}, 32'd0);
        @(posedge Clk);
        model_clear();
        @(negedge Clk);
        clr = 1'b0;
        chk("clr_sum_kept", {16'd0, sum_a}, 32'd18);
        chk("clr_valid", {31'd0, sum_valid_a}, 32'd0);
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        prod_valid = 1'b0;
        get_result("clr");
        @(negedge Clk);

        // Asynchronous reset while holding a result
        sum_ready = 1'b0;
        send(8'd10); send(8'd20); send(8'd30); send(8'd40);
        prod_valid = 1'b0;
        get_result("pre_rst");
        #2;
        Rst = 1'b0;
        #1;
        chk("arst_sum", {16'd0, sum_a}, 32'd0);
        chk("arst_valid", {31'd0, sum_valid_a}, 32'd0);
        chk("arst_ovf9", {31'd0, ovf_b}, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        sum_ready = 1'b1;
        model_clear();
        #1;
        chk("arst_pready", {31'd0, prod_ready_a}, 32'd1);
        @(negedge Clk);
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        prod_valid = 1'b0;
        get_result("arst_next");
        @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
